// File: rtl/age_priority_resource_arbiter.sv
// age_priority_resource_arbiter: grants a shared resource to the oldest eligible requester,
// optionally locking it to the owner until completion or abort.
module age_priority_resource_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 4,
  parameter int PAYLOAD_W   = 64,
  parameter int MULTI_CYCLE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]  i_req_id,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] i_req_payload,
  input  logic [ID_WIDTH-1:0]          i_head_id,
  input  logic [NUM_REQ-1:0]           i_abort,
  input  logic                         i_res_done,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_res_valid,
  output logic [PAYLOAD_W-1:0]         o_res_payload,
  output logic [$clog2(NUM_REQ)-1:0]   o_res_owner,
  output logic                         o_busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int P  = 1 << IW;
  typedef enum logic {IDLE, LOCK} state_t;
  state_t                 r_state, w_next;
  logic [IW-1:0]          r_owner;
  logic [PAYLOAD_W-1:0]   r_payload;
  logic                   r_cool;
  logic [P-1:0]           w_elig, w_abort;
  logic [P*ID_WIDTH-1:0]  w_ids;
  logic [P*PAYLOAD_W-1:0] w_pays;
  logic                   w_v [2*P-1];
  logic [ID_WIDTH-1:0]    w_a [2*P-1];
  logic [IW-1:0]          w_i [2*P-1];
  logic                   w_l [P-1];
  logic                   w_fire, w_lock, w_own_abort;
  logic [IW-1:0]          w_win;
  logic [PAYLOAD_W-1:0]   w_win_pay;
  // Pad to a power of two so the comparison tree is balanced; padded leaves are never eligible.
  assign w_elig      = P'(i_req_valid & ~i_abort);
  assign w_abort     = P'(i_abort);
  assign w_ids       = (P*ID_WIDTH)'(i_req_id);
  assign w_pays      = (P*PAYLOAD_W)'(i_req_payload);
  assign w_own_abort = w_abort[r_owner];
  always_comb begin
    for (int n = 0; n < P; n++) begin
      w_v[P-1+n] = w_elig[n];
      w_a[P-1+n] = w_ids[n*ID_WIDTH +: ID_WIDTH] - i_head_id;
      w_i[P-1+n] = IW'(n);
    end
    for (int n = P-2; n >= 0; n--) begin
      w_l[n]   = w_v[2*n+1] & (~w_v[2*n+2] | (w_a[2*n+1] <= w_a[2*n+2]));
      w_v[n]   = w_v[2*n+1] | w_v[2*n+2];
      w_a[n]   = w_l[n] ? w_a[2*n+1] : w_a[2*n+2];
      w_i[n]   = w_l[n] ? w_i[2*n+1] : w_i[2*n+2];
    end
  end
  assign w_win     = w_i[0];
  assign w_win_pay = w_pays[int'(w_win)*PAYLOAD_W +: PAYLOAD_W];
  // r_cool marks the LOCK exit cycle, during which no new grant is issued.
  assign w_fire = rst_n & (r_state == IDLE) & ~r_cool & w_v[0];
  assign w_lock = rst_n & (r_state == LOCK);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_payload <= '0;
      r_cool    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cool  <= (r_state == LOCK) && (w_next == IDLE);
      if (r_state == IDLE && w_next == LOCK) begin
        r_owner   <= w_win;
        r_payload <= w_win_pay;
      end
    end
  end
  always_comb begin
    w_next = (r_state == LOCK) ? ((w_own_abort | i_res_done) ? IDLE : LOCK)
                               : ((MULTI_CYCLE != 0 && w_fire) ? LOCK : IDLE);
  end
  always_comb begin
    o_grant       = w_lock ? ((NUM_REQ'(1) << r_owner) & {NUM_REQ{~w_own_abort}})
                           : (w_fire ? NUM_REQ'(1) << w_win : '0);
    o_res_valid   = w_fire;
    o_busy        = w_lock;
    o_res_owner   = w_lock ? r_owner : (w_fire ? w_win : '0);
    o_res_payload = w_lock ? r_payload : (w_fire ? w_win_pay : '0);
  end
endmodule

// File: tb/tb_age_priority_resource_arbiter.sv
// tb_age_priority_resource_arbiter: scoreboard bench driving a single-cycle and a locking arbiter
// with shared stimulus; expectations are queued at drive time and checked before the next edge.
module tb_age_priority_resource_arbiter;
  localparam int N = 4, IDW = 4, PW = 64;
  localparam int G0 = 0, V0 = 1, B0 = 2, O0 = 3, P0 = 4, G1 = 5, V1 = 6, B1 = 7, O1 = 8, P1 = 9;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req_valid = '0, abort = '0;
  logic [N*IDW-1:0] req_id = '0;
  logic [N*PW-1:0] req_payload;
  logic [IDW-1:0] head_id = '0;
  logic res_done = 0;
  logic [N-1:0] g0, g1;
  logic v0, v1, b0, b1;
  logic [PW-1:0] p0, p1;
  logic [1:0] o0, o1;
  int n_checks = 0, n_errors = 0;
  typedef struct {string tag; int sel; logic [63:0] exp;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  age_priority_resource_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW), .PAYLOAD_W(PW), .MULTI_CYCLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_id(req_id), .i_req_payload(req_payload),
    .i_head_id(head_id), .i_abort(abort), .i_res_done(1'b0), .o_grant(g0), .o_res_valid(v0),
    .o_res_payload(p0), .o_res_owner(o0), .o_busy(b0));
  age_priority_resource_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW), .PAYLOAD_W(PW), .MULTI_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_req_valid(req_valid), .i_req_id(req_id), .i_req_payload(req_payload),
    .i_head_id(head_id), .i_abort(abort), .i_res_done(res_done), .o_grant(g1), .o_res_valid(v1),
    .o_res_payload(p1), .o_res_owner(o1), .o_busy(b1));
  function automatic logic [63:0] pay(int i);
    return 64'h1111_0000 + 64'(i);
  endfunction
  function automatic logic [63:0] obs(int s);
    case (s)
      G0: return 64'(g0);  V0: return 64'(v0);  B0: return 64'(b0);  O0: return 64'(o0);  P0: return p0;
      G1: return 64'(g1);  V1: return 64'(v1);  B1: return 64'(b1);  O1: return 64'(o1);  default: return p1;
    endcase
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(string tag, int sel, logic [63:0] v);
    sb.push_back('{tag, sel, v});
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sel), e.exp);
    end
  endtask
  task automatic cyc();
    #4;
    drain();
    @(negedge clk);
  endtask
  task automatic drive(logic [N-1:0] v, logic [N*IDW-1:0] ids, logic [IDW-1:0] h, logic [N-1:0] ab, logic d);
    req_valid = v; req_id = ids; head_id = h; abort = ab; res_done = d;
  endtask
  initial begin
    for (int i = 0; i < N; i++) req_payload[i*PW +: PW] = pay(i);
    drive(4'b1111, 16'h0000, 4'd0, 4'b0000, 1'b1);
    #1;
    push("rst_g0", G0, 0); push("rst_g1", G1, 0); push("rst_v1", V1, 0);
    push("rst_b1", B1, 0); push("rst_p1", P1, 0); push("rst_o1", O1, 0);
    drain();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    drive(4'b0000, 16'h0000, 4'd0, 4'b0000, 1'b0);
    push("idle_g0", G0, 0); push("idle_v0", V0, 0); push("idle_p0", P0, 0); push("idle_g1", G1, 0);
    cyc();
    // wrap-around age: head 14, id1 -> age 3, id15 -> age 1
    drive(4'b0101, 16'h0F01, 4'd14, 4'b0000, 1'b0);
    push("wrap_g0", G0, 4'b0100); push("wrap_o0", O0, 2); push("wrap_v0", V0, 1);
    push("wrap_g1", G1, 4'b0100); push("wrap_v1", V1, 1); push("wrap_b1", B1, 0);
    cyc();
    drive(4'b1010, 16'h5050, 4'd5, 4'b0000, 1'b1);
    push("tie_g0", G0, 4'b0010); push("lk2_g1", G1, 4'b0100); push("lk2_b1", B1, 1);
    push("lk2_v1", V1, 0); push("lk2_p1", P1, pay(2)); push("lk2_o1", O1, 2);
    cyc();
    drive(4'b1010, 16'h5050, 4'd5, 4'b0010, 1'b0);
    push("tie_abort_g0", G0, 4'b1000); push("exit_g1", G1, 0); push("exit_b1", B1, 0); push("exit_v1", V1, 0);
    cyc();
    for (int c = 0; c < 3; c++) begin
      drive(4'b0001, 16'h0000, 4'd0, 4'b0000, c == 2);
      push("sc_g0", G0, 4'b0001); push("sc_v0", V0, 1); push("sc_b0", B0, 0); push("sc_p0", P0, pay(0));
      push("sc_g1", G1, 4'b0001); push("sc_b1", B1, c != 0);
      cyc();
    end
    drive(4'b0000, 16'h0000, 4'd0, 4'b0000, 1'b0);
    push("sc_exit_b1", B1, 0);
    cyc();
    cyc();
    // lock: req1 id3 owns; older req3 id2 must wait until after exit cycle
    for (int c = 0; c <= 7; c++) begin
      drive(c == 0 ? 4'b0010 : 4'b1010, 16'h2030, 4'd0, 4'b0000, c == 5);
      if (c <= 5) push("lock_g1", G1, 4'b0010);
      if (c >= 1 && c <= 5) push("lock_b1", B1, 1);
      if (c >= 1 && c <= 5) push("lock_v1", V1, 0);
      if (c == 6) begin push("lock_exit_g1", G1, 0); push("lock_exit_b1", B1, 0); end
      if (c == 7) begin push("lock_next_g1", G1, 4'b1000); push("lock_next_v1", V1, 1); push("lock_next_o1", O1, 3); end
      cyc();
    end
    drive(4'b0000, 16'h2030, 4'd0, 4'b1000, 1'b1);
    push("abort_done_g1", G1, 0); push("abort_done_b1", B1, 1);
    cyc();
    drive(4'b0000, 16'h0000, 4'd0, 4'b0000, 1'b0);
    push("abort_done_exit_b1", B1, 0);
    cyc();
    // abort mid-lock with pending req0
    for (int c = 0; c <= 5; c++) begin
      drive(c == 0 ? 4'b0100 : (c <= 3 ? 4'b0101 : 4'b0001), 16'h0001, 4'd0, c == 3 ? 4'b0100 : 4'b0000, 1'b0);
      if (c <= 2) push("ab_g1", G1, 4'b0100);
      if (c == 3) begin push("ab_g1_kill", G1, 0); push("ab_b1_kill", B1, 1); end
      if (c == 4) begin push("ab_b1_exit", B1, 0); push("ab_g1_exit", G1, 0); end
      if (c == 5) begin push("ab_g1_next", G1, 4'b0001); push("ab_v1_next", V1, 1); end
      cyc();
    end
    // dut1 now locked on req0; reset asynchronously mid-cycle
    #2;
    push("pre_rst_b1", B1, 1); push("pre_rst_g1", G1, 4'b0001);
    drain();
    rst_n = 0;
    #1;
    push("arst_g1", G1, 0); push("arst_b1", B1, 0); push("arst_v1", V1, 0); push("arst_g0", G0, 0);
    drain();
    @(negedge clk);
    rst_n = 1;
    push("post_rst_g1", G1, 4'b0001); push("post_rst_v1", V1, 1);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/age_priority_resource_arbiter.md
# age_priority_resource_arbiter

Shares one execution resource (ALU, memory port or mul/div unit) between `NUM_REQ` single-instruction controllers. When several controllers request the resource, the oldest in-flight instruction wins, with age measured by wrap-around issue ID. In multi-cycle mode the arbiter locks the resource to its owner until the resource reports completion or the owner is aborted. It sits between the SIC `*_rpl`/`*_req` outputs and the shared unit, and drives the per-SIC `*_grant` inputs.

## Interface
- `NUM_REQ`, default 4: number of requesting SICs, range 2..8.
- `ID_WIDTH`, default 4: issue-ID width.
- `PAYLOAD_W`, default 64: width of the request payload forwarded to the resource.
- `MULTI_CYCLE`, default 0: 0 = resource finishes in one cycle with no lock; 1 = lock until `res_done`.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, `NUM_REQ`: per-SIC request.
- `req_id`, in, `NUM_REQ*ID_WIDTH`: issue ID of each request; slice i belongs to SIC i.
- `req_payload`, in, `NUM_REQ*PAYLOAD_W`: operands/command of each request.
- `head_id`, in, `ID_WIDTH`: issue ID of the oldest uncommitted instruction.
- `abort`, in, `NUM_REQ`: per-SIC kill (flush); cancels that SIC's request or lock.
- `res_done`, in, 1: resource completion pulse. Used only when `MULTI_CYCLE=1`.
- `grant`, out, `NUM_REQ`: one-hot or zero grant to the SICs.
- `res_valid`, out, 1: start strobe to the resource.
- `res_payload`, out, `PAYLOAD_W`: payload of the winning or owning SIC.
- `res_owner`, out, `$clog2(NUM_REQ)`: index of the current winner or owner.
- `busy`, out, 1: high while the arbiter is in the LOCK state.

## Operation
- Eligibility: `elig[i] = req_valid[i] & ~abort[i]`.
- Age: `age[i] = (req_id[i] - head_id) mod 2^ID_WIDTH`, computed as an unsigned `ID_WIDTH`-bit subtraction.
- Winner selection:
  - The winner is the eligible SIC with the smallest age.
  - On equal age, the lower index wins.
  - Selection is a fully combinational tree.
- FSM states: IDLE, LOCK. LOCK is unreachable when `MULTI_CYCLE=0`.
- IDLE with at least one eligible SIC:
  - `grant[w]=1`, `res_valid=1`, `res_payload=req_payload[w]`, `res_owner=w`.
  - If `MULTI_CYCLE=1`: latch `owner_r<=w` and `payload_r`, then move to LOCK.
- IDLE with no eligible SIC: `grant=0`, `res_valid=0`, `res_owner=0`, `res_payload=0`.
- LOCK:
  - Outputs: `grant[owner_r]=~abort[owner_r]`, `res_valid=0`, `res_payload=payload_r`, `res_owner=owner_r`, `busy=1`.
  - All other requests are ignored, including older ones. No preemption.
  - The owner dropping `req_valid` does not release the lock.
- LOCK exit:
  - `res_done` with the owner not aborted: grant stays high that cycle so the owner captures the result; return to IDLE next cycle.
  - `abort[owner_r]`: grant drops in the same cycle; return to IDLE next cycle.
  - `abort` and `res_done` in the same cycle: abort wins. Grant is 0 and the result is discarded.
- Leaving LOCK takes one cycle. No re-arbitration happens in the exit cycle; a new grant is possible at the earliest one cycle after the exit.
- `res_done` seen in IDLE is ignored.
- `head_id` may change at any time. Ages are recomputed every cycle, and the lock owner is never affected by a `head_id` change.

## Timing
- Reset (asynchronous): state IDLE, `owner_r=0`, `payload_r=0`.
- Outputs while reset is asserted: `grant=0`, `res_valid=0`, `busy=0`, `res_owner=0`, `res_payload=0`. All grant gating is forced off during reset.
- Reset during LOCK: the lock is dropped immediately, with no `res_done` required.
- Grant latency is 0 cycles: combinational from `req_valid`/`req_id`/`head_id` in IDLE. Outputs must be glitch-tolerant at the clock edge only.
- `MULTI_CYCLE=0`: a SIC may win on consecutive cycles. Throughput is 1 grant per cycle.
- `MULTI_CYCLE=1`: minimum occupancy is 2 cycles (grant cycle, then LOCK with `res_done`) plus 1 exit cycle.
- `busy` is registered-state derived: it rises the cycle after the grant and falls the cycle after `res_done` or abort.

## Test plan
- Wrap-around age: `N=4`, `ID_WIDTH=4`, `head_id=14`, req0 id=1, req2 id=15 (both valid) -> `grant=4'b0100`, `res_owner=2`, `res_valid=1` in the same cycle.
- Tie: req1 and req3 both id=5, `head_id=5` -> `grant=4'b0010`. Add `abort[1]=1` -> `grant=4'b1000`.
- Lock, `MULTI_CYCLE=1`:
  - Stimulus: req1 id=3 granted at cycle 0; req3 id=2 (older) raised at cycle 1; `res_done` at cycle 5.
  - Required: `grant=0010` on cycles 0-5, `busy=1` on cycles 1-5, `grant=0000` on cycle 6, `grant=1000` with `res_valid=1` on cycle 7.
- Abort mid-lock: owner=2 in LOCK, `abort[2]` pulse at cycle 3 -> `grant=0` in cycle 3, `busy=0` in cycle 4, a pending req0 is granted in cycle 5. Abort coincident with `res_done` -> grant=0 in that cycle.
- Reset mid-LOCK: assert `rst_n=0` asynchronously while `busy=1` -> `grant`, `busy`, `res_valid` go 0 immediately. After release with req0 valid, `grant=0001` with no `res_done` needed.
- Idle and single-cycle mode:
  - No requests: `grant=0`, `res_valid=0`, `res_payload=0`.
  - `MULTI_CYCLE=0` with req0 held valid for 3 cycles: `grant=0001` and `res_valid=1` every cycle, `busy=0` throughout.
